corr_score_engine: RTL and testbench

// Parametrised template-correlation engine: for one window start (iXstart,iYstart) it raster-scans a
// TPL_W x TPL_H template, fetches SRAM frame pixels and search-template pixels, and accumulates either
// SAD or similarity. It has a start/busy/valid handshake and compensates read latency. It also keeps
// a running best match across windows for the search controller.

---
 rtl/corr_score_engine.sv | 142 ++++++++++++++
 tb/tb_corr_score_engine.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/corr_score_engine.sv
// Template-correlation engine: raster-scans a TPL_W x TPL_H window, accumulates SAD or similarity
// over latency-compensated pixel pairs, and tracks the best-scoring window origin.
module corr_score_engine #(
  parameter int unsigned PIX_W   = 10,
  parameter int unsigned COORD_W = 13,
  parameter int unsigned TPL_W   = 64,
  parameter int unsigned TPL_H   = 48,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned SCORE_W = 32
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iStart,
  input  logic               iMode,
  input  logic [COORD_W-1:0] iXstart,
  input  logic [COORD_W-1:0] iYstart,
  input  logic               iClearBest,
  input  logic [PIX_W-1:0]   reading_sram,
  input  logic [PIX_W-1:0]   reading_search,
  output logic [COORD_W-1:0] oX_sram,
  output logic [COORD_W-1:0] oY_sram,
  output logic [COORD_W-1:0] oX_search,
  output logic [COORD_W-1:0] oY_search,
  output logic               oAddrValid,
  output logic               oBusy,
  output logic               oValid,
  output logic [SCORE_W-1:0] oScore,
  output logic [SCORE_W-1:0] oBestScore,
  output logic [COORD_W-1:0] oBestX,
  output logic [COORD_W-1:0] oBestY,
  output logic               oBestValid
);

  typedef enum logic [1:0] {StIdle, StAddr, StDrain, StDone} stateT;

  localparam logic [PIX_W-1:0]   MaxPix   = '1;
  localparam logic [COORD_W-1:0] LastX    = COORD_W'(TPL_W - 1);
  localparam logic [COORD_W-1:0] LastY    = COORD_W'(TPL_H - 1);
  // Only the oldest tap set: the final sample is being consumed this cycle.
  localparam logic [RD_LAT-1:0]  LastOnly = RD_LAT'(1) << (RD_LAT - 1);

  stateT              state;
  logic [COORD_W-1:0] xOrg, yOrg;
  logic               modeSad;
  logic [RD_LAT-1:0]  vldPipe;
  logic [SCORE_W-1:0] acc;

  logic [PIX_W-1:0]   absDiff;
  logic [PIX_W-1:0]   term;
  logic [SCORE_W-1:0] accNext;
  logic               isBetter;
  logic [COORD_W-1:0] xNext, yNext;

  always_comb begin
    absDiff  = (reading_sram > reading_search) ? reading_sram - reading_search
                                               : reading_search - reading_sram;
    term     = modeSad ? absDiff : MaxPix - absDiff;
    accNext  = acc + SCORE_W'(term);
    isBetter = !oBestValid || (modeSad ? (oScore < oBestScore) : (oScore > oBestScore));
    xNext    = oX_search + COORD_W'(1);
    yNext    = oY_search + COORD_W'(1);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state      <= StIdle;
      xOrg       <= '0;
      yOrg       <= '0;
      modeSad    <= 1'b0;
      vldPipe    <= '0;
      acc        <= '0;
      oX_sram    <= '0;
      oY_sram    <= '0;
      oX_search  <= '0;
      oY_search  <= '0;
      oAddrValid <= 1'b0;
      oBusy      <= 1'b0;
      oValid     <= 1'b0;
      oScore     <= '0;
      oBestScore <= '0;
      oBestX     <= '0;
      oBestY     <= '0;
      oBestValid <= 1'b0;
    end else begin
      vldPipe <= (vldPipe << 1) | RD_LAT'(oAddrValid);
      if (vldPipe[RD_LAT-1]) acc <= accNext;
      oValid <= 1'b0;
      if (iClearBest) oBestValid <= 1'b0;

      case (state)
        StIdle: begin
          if (iStart) begin
            state      <= StAddr;
            xOrg       <= iXstart;
            yOrg       <= iYstart;
            modeSad    <= iMode;
            acc        <= '0;
            oX_search  <= '0;
            oY_search  <= '0;
            oX_sram    <= iXstart;
            oY_sram    <= iYstart;
            oAddrValid <= 1'b1;
            oBusy      <= 1'b1;
          end
        end
        StAddr: begin
          if (oX_search != LastX) begin
            oX_search <= xNext;
            oX_sram   <= xOrg + xNext;
          end else if (oY_search != LastY) begin
            oX_search <= '0;
            oY_search <= yNext;
            oX_sram   <= xOrg;
            oY_sram   <= yOrg + yNext;
          end else begin
            oAddrValid <= 1'b0;
            state      <= StDrain;
          end
        end
        StDrain: begin
          if (vldPipe == LastOnly) begin
            state  <= StDone;
            oValid <= 1'b1;
            oScore <= accNext;
            oBusy  <= 1'b0;
          end
        end
        StDone: begin
          state <= StIdle;
          if (iClearBest || isBetter) begin
            oBestScore <= oScore;
            oBestX     <= xOrg;
            oBestY     <= yOrg;
            oBestValid <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_corr_score_engine.sv
// Directed bench for corr_score_engine with a 4x2 template and two-cycle read latency.
module tb_corr_score_engine;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iStart = 1'b0;
  logic        iMode = 1'b0;
  logic [12:0] iXstart = '0;
  logic [12:0] iYstart = '0;
  logic        iClearBest = 1'b0;
  logic [9:0]  reading_sram;
  logic [9:0]  reading_search;
  logic [12:0] oX_sram, oY_sram, oX_search, oY_search;
  logic        oAddrValid, oBusy, oValid, oBestValid;
  logic [31:0] oScore, oBestScore;
  logic [12:0] oBestX, oBestY;

  logic [9:0]  sramConst = '0;
  logic [9:0]  searchConst = '0;
  logic        useModel = 1'b0;
  logic [9:0]  pipe1 = '0;
  logic [9:0]  pipe2 = '0;

  int nChecks = 0;
  int nFail = 0;

  always #5 iCLK = ~iCLK;

  // Template memory model: pixel = x + 4*y, returned two cycles after its address.
  always @(posedge iCLK) begin
    pipe1 <= oX_search[9:0] + {oY_search[7:0], 2'b00};
    pipe2 <= pipe1;
  end

  assign reading_sram   = sramConst;
  assign reading_search = useModel ? pipe2 : searchConst;

  corr_score_engine #(
    .PIX_W(10), .COORD_W(13), .TPL_W(4), .TPL_H(2), .RD_LAT(2), .SCORE_W(32)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iMode(iMode),
    .iXstart(iXstart), .iYstart(iYstart), .iClearBest(iClearBest),
    .reading_sram(reading_sram), .reading_search(reading_search),
    .oX_sram(oX_sram), .oY_sram(oY_sram), .oX_search(oX_search), .oY_search(oY_search),
    .oAddrValid(oAddrValid), .oBusy(oBusy), .oValid(oValid), .oScore(oScore),
    .oBestScore(oBestScore), .oBestX(oBestX), .oBestY(oBestY), .oBestValid(oBestValid)
  );

  // Starts a window (cycle 0) and returns its score and the cycle oValid was seen; ends in cycle+1.
  task automatic runWindow(input logic mode, input logic [12:0] xs, input logic [12:0] ys,
                           input logic clrAtDone, output logic [31:0] score, output int vc);
    @(negedge iCLK);
    iMode = mode; iXstart = xs; iYstart = ys; iStart = 1'b1;
    vc = -1;
    score = '0;
    for (int c = 1; c <= 40 && vc < 0; c++) begin
      @(negedge iCLK);
      iStart = 1'b0;
      if (oValid) begin
        vc = c;
        score = oScore;
        if (clrAtDone) iClearBest = 1'b1;
      end
    end
    @(negedge iCLK);
    iClearBest = 1'b0;
  endtask

  task automatic test_reset;
    iRST = 1'b1;
    repeat (3) @(negedge iCLK);
    nChecks++;
    if ({oAddrValid, oBusy, oValid, oBestValid} !== 4'b0) begin
      nFail++; $display("FAIL reset_flags got %b exp 0000", {oAddrValid, oBusy, oValid, oBestValid});
    end
    nChecks++;
    if ({oScore, oBestScore, oX_sram, oY_sram, oX_search, oY_search} !== '0) begin
      nFail++; $display("FAIL reset_data score=%0d best=%0d xs=%0d ys=%0d", oScore, oBestScore,
                        oX_sram, oY_sram);
    end
    iRST = 1'b0;
  endtask

  task automatic test_sim_timing;
    sramConst = 10'd500; searchConst = 10'd500; useModel = 1'b0;
    @(negedge iCLK);
    iMode = 1'b0; iXstart = 13'd0; iYstart = 13'd0; iStart = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge iCLK);
      iStart = 1'b0;
      nChecks++;
      if (oValid !== (c == 11)) begin
        nFail++; $display("FAIL sim_valid cycle %0d got %b exp %b", c, oValid, c == 11);
      end
      nChecks++;
      if (oAddrValid !== (c <= 8)) begin
        nFail++; $display("FAIL sim_addrvalid cycle %0d got %b exp %b", c, oAddrValid, c <= 8);
      end
      nChecks++;
      if (oBusy !== (c <= 10)) begin
        nFail++; $display("FAIL sim_busy cycle %0d got %b exp %b", c, oBusy, c <= 10);
      end
      if (c == 11) begin
        nChecks++;
        if (oScore !== 32'd8184) begin
          nFail++; $display("FAIL sim_score got %0d exp 8184", oScore);
        end
      end
    end
  endtask

  task automatic test_sad;
    logic [31:0] s;
    int vc;
    logic [9:0] sv [3];
    logic [9:0] tv [3];
    logic [31:0] ev [3];
    sv = '{10'd100, 10'd90, 10'd0};
    tv = '{10'd90, 10'd100, 10'd1023};
    ev = '{32'd80, 32'd80, 32'd8184};
    useModel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sramConst = sv[i]; searchConst = tv[i];
      runWindow(1'b1, 13'd0, 13'd0, 1'b0, s, vc);
      nChecks++;
      if (s !== ev[i] || vc != 11) begin
        nFail++; $display("FAIL sad_%0d score %0d at cycle %0d exp %0d at 11", i, s, vc, ev[i]);
      end
    end
  endtask

  task automatic test_pattern;
    logic [31:0] s;
    int vc;
    sramConst = 10'd0; useModel = 1'b1;
    runWindow(1'b1, 13'd2, 13'd1, 1'b0, s, vc);
    nChecks++;
    if (s !== 32'd28 || vc != 11) begin
      nFail++; $display("FAIL pattern_sad score %0d at cycle %0d exp 28 at 11", s, vc);
    end
    runWindow(1'b0, 13'd2, 13'd1, 1'b0, s, vc);
    nChecks++;
    if (s !== 32'd8156 || vc != 11) begin
      nFail++; $display("FAIL pattern_sim score %0d at cycle %0d exp 8156 at 11", s, vc);
    end
    useModel = 1'b0;
  endtask

  task automatic test_best;
    logic [31:0] s;
    int vc;
    @(negedge iCLK); iClearBest = 1'b1;
    @(negedge iCLK); iClearBest = 1'b0;
    nChecks++;
    if (oBestValid !== 1'b0) begin
      nFail++; $display("FAIL best_clear got %b exp 0", oBestValid);
    end
    sramConst = 10'd100;
    searchConst = 10'd90;
    runWindow(1'b1, 13'd0, 13'd0, 1'b0, s, vc);
    nChecks++;
    if ({oBestValid, oBestScore, oBestX, oBestY} !== {1'b1, 32'd80, 13'd0, 13'd0}) begin
      nFail++; $display("FAIL best_w1 got v=%b %0d (%0d,%0d) exp 1 80 (0,0)", oBestValid,
                        oBestScore, oBestX, oBestY);
    end
    searchConst = 10'd95;
    runWindow(1'b1, 13'd5, 13'd0, 1'b0, s, vc);
    nChecks++;
    if ({oBestScore, oBestX, oBestY} !== {32'd40, 13'd5, 13'd0}) begin
      nFail++; $display("FAIL best_w2 got %0d (%0d,%0d) exp 40 (5,0)", oBestScore, oBestX, oBestY);
    end
    runWindow(1'b1, 13'd9, 13'd3, 1'b0, s, vc);
    nChecks++;
    if ({s, oBestScore, oBestX, oBestY} !== {32'd40, 32'd40, 13'd5, 13'd0}) begin
      nFail++; $display("FAIL best_tie score %0d best %0d (%0d,%0d) exp 40 40 (5,0)", s,
                        oBestScore, oBestX, oBestY);
    end
    searchConst = 10'd75;
    runWindow(1'b1, 13'd7, 13'd7, 1'b1, s, vc);
    nChecks++;
    if ({oBestValid, oBestScore, oBestX, oBestY} !== {1'b1, 32'd200, 13'd7, 13'd7}) begin
      nFail++; $display("FAIL best_clear_done got v=%b %0d (%0d,%0d) exp 1 200 (7,7)",
                        oBestValid, oBestScore, oBestX, oBestY);
    end
  endtask

  task automatic test_back_to_back;
    sramConst = 10'd100; searchConst = 10'd90;
    @(negedge iCLK);
    iMode = 1'b1; iXstart = 13'd20; iYstart = 13'd0; iStart = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge iCLK);
      nChecks++;
      if (oValid !== (c == 11 || c == 23)) begin
        nFail++; $display("FAIL b2b_valid cycle %0d got %b exp %b", c, oValid, c == 11 || c == 23);
      end
      if (c == 4) begin
        nChecks++;
        if (oX_sram !== 13'd23) begin
          nFail++; $display("FAIL b2b_ignored_start got x %0d exp 23", oX_sram);
        end
      end
      if (c == 13) begin
        nChecks++;
        if (oBusy !== 1'b1 || oX_sram !== 13'd40) begin
          nFail++; $display("FAIL b2b_restart got busy %b x %0d exp 1 40", oBusy, oX_sram);
        end
      end
      if (c == 23) begin
        nChecks++;
        if (oScore !== 32'd80) begin
          nFail++; $display("FAIL b2b_score got %0d exp 80", oScore);
        end
      end
      iStart  = (c == 3 || c == 11 || c == 12);
      iXstart = (c == 12) ? 13'd40 : 13'd30;
    end
    iStart = 1'b0;
  endtask

  task automatic test_mid_reset;
    logic [31:0] s;
    int vc;
    sramConst = 10'd100; searchConst = 10'd90;
    @(negedge iCLK);
    iMode = 1'b1; iXstart = 13'd1; iYstart = 13'd1; iStart = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge iCLK);
      iStart = 1'b0;
      if (c == 6) begin
        nChecks++;
        if ({oAddrValid, oBusy, oBestValid, oScore, oX_sram, oY_search} !== '0) begin
          nFail++; $display("FAIL rst_outputs got av=%b busy=%b bv=%b score=%0d x=%0d", oAddrValid,
                            oBusy, oBestValid, oScore, oX_sram);
        end
      end
      if (c >= 6) begin
        nChecks++;
        if (oValid !== 1'b0) begin
          nFail++; $display("FAIL rst_no_valid cycle %0d got 1 exp 0", c);
        end
      end
      iRST = (c == 5);
    end
    runWindow(1'b1, 13'd3, 13'd4, 1'b0, s, vc);
    nChecks++;
    if (s !== 32'd80 || vc != 11 || {oBestScore, oBestX, oBestY} !== {32'd80, 13'd3, 13'd4}) begin
      nFail++; $display("FAIL rst_restart score %0d cycle %0d best %0d (%0d,%0d) exp 80 11 80 (3,4)",
                        s, vc, oBestScore, oBestX, oBestY);
    end
  endtask

  task automatic test_wrap;
    logic [12:0] ex [8];
    logic [12:0] ey [8];
    ex = '{13'd8190, 13'd8191, 13'd0, 13'd1, 13'd8190, 13'd8191, 13'd0, 13'd1};
    ey = '{13'd8191, 13'd8191, 13'd8191, 13'd8191, 13'd0, 13'd0, 13'd0, 13'd0};
    @(negedge iCLK);
    iMode = 1'b1; iXstart = 13'd8190; iYstart = 13'd8191; iStart = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge iCLK);
      iStart = 1'b0;
      if (c <= 8) begin
        nChecks++;
        if (oX_sram !== ex[c-1] || oY_sram !== ey[c-1]) begin
          nFail++; $display("FAIL wrap cycle %0d got (%0d,%0d) exp (%0d,%0d)", c, oX_sram, oY_sram,
                            ex[c-1], ey[c-1]);
        end
      end
      if (c == 10) begin
        nChecks++;
        if (oX_sram !== 13'd1 || oY_sram !== 13'd0) begin
          nFail++; $display("FAIL wrap_hold got (%0d,%0d) exp (1,0)", oX_sram, oY_sram);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_sim_timing();
    test_sad();
    test_pattern();
    test_best();
    test_back_to_back();
    test_mid_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
